width_down_serializer: RTL and testbench

- Parametrised successor of the fixed 8/16/32-to-8-bit converter.
- Accepts one parallel word of 1, 2, 4, … up to MAX_LANES lanes per transfer, selected per word by dataS.
- Emits the word one LANE_W-bit lane per cycle on a single clock, with valid/ready handshakes on both sides and an end-of-word marker.
- Sits between the parallel datapath and the byte-wide serial/PHY front end, replacing the multi-clock (clk16/clk32) scheme with one clock plus flow control.

---
 rtl/width_down_serializer.sv | 119 +++++++++++
 tb/tb_width_down_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/width_down_serializer.sv
// Width-down serializer: takes one parallel word of 1..MAX_LANES lanes
// (a power of two chosen per word by dataS) and emits it one LANE_W-bit
// lane per cycle, with valid/ready on both sides and an end-of-word flag.
module width_down_serializer #(
   parameter int LANE_W    = 8,
   parameter int MAX_LANES = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enb,
   input  logic [2:0]                  dataS,
   input  logic [LANE_W*MAX_LANES-1:0] dataIn,
   input  logic                        inValid,
   output logic                        inReady,
   output logic [LANE_W-1:0]           dataOut,
   output logic                        outValid,
   input  logic                        outReady,
   output logic                        outLast,
   output logic                        busy
);

   localparam int WORD_W  = LANE_W * MAX_LANES;
   localparam int SEL_MAX = $clog2(MAX_LANES);
   // Counter must hold MAX_LANES itself, hence one extra bit.
   localparam int CNT_W   = SEL_MAX + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WORD_W-1:0]   sr_q;
   logic [LANE_W-1:0]   dout_q;

   logic [CNT_W-1:0]    lanes_d;
   logic [LANE_W-1:0]   first_lane;
   logic [WORD_W-1:0]   first_rest;
   logic [LANE_W-1:0]   next_lane;
   logic [WORD_W-1:0]   next_rest;
   logic                last_lane;
   logic                accept;
   logic                xfer;

   // Lane count of the offered word; oversized selects saturate to MAX_LANES.
   always_comb begin
      if (int'(dataS) > SEL_MAX) begin
         lanes_d = CNT_W'(MAX_LANES);
      end else begin
         lanes_d = CNT_W'(1) << dataS;
      end
   end

   generate
      if (MSB_FIRST) begin : g_msb_first
         logic [WORD_W-1:0] aligned;
         // Left-justify the used lanes so the top lane is always emitted
         // next; unused upper lanes fall off the top of the shift.
         always_comb begin
            aligned    = dataIn << (LANE_W * (MAX_LANES - int'(lanes_d)));
            first_lane = aligned[WORD_W-1 -: LANE_W];
            first_rest = aligned << LANE_W;
            next_lane  = sr_q[WORD_W-1 -: LANE_W];
            next_rest  = sr_q << LANE_W;
         end
      end else begin : g_lsb_first
         // Lane 0 goes out first; the remainder shifts down toward lane 0.
         // Unused upper lanes may remain in the register but are never
         // reached because the counter ends the word first.
         always_comb begin
            first_lane = dataIn[LANE_W-1:0];
            first_rest = dataIn >> LANE_W;
            next_lane  = sr_q[LANE_W-1:0];
            next_rest  = sr_q >> LANE_W;
         end
      end
   endgenerate

   // Handshake qualifiers; a new word may enter on the same edge the
   // previous word's final lane leaves, so back-to-back words have no gap.
   always_comb begin
      last_lane = (cnt_q == CNT_W'(1));
      inReady   = enb & ~rst & ((state_q == IDLE) | (last_lane & outReady));
      outValid  = enb & (state_q == SHIFT);
      outLast   = outValid & last_lane;
      accept    = enb & inValid & inReady;
      xfer      = outValid & outReady;
      busy      = (state_q == SHIFT);
      dataOut   = dout_q;
   end

   // Control FSM and datapath: load on accept, advance one lane per transfer,
   // hold everything while disabled or backpressured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         dout_q  <= '0;
      end else if (enb) begin
         if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= lanes_d;
            sr_q    <= first_rest;
            dout_q  <= first_lane;
         end else if (xfer) begin
            if (last_lane) begin
               // Word finished with nothing queued: dataOut keeps its value.
               state_q <= IDLE;
               cnt_q   <= '0;
            end else begin
               cnt_q  <= cnt_q - CNT_W'(1);
               sr_q   <= next_rest;
               dout_q <= next_lane;
            end
         end
      end
   end

endmodule

// File: tb/tb_width_down_serializer.sv
// Directed bench for width_down_serializer (LANE_W=8, MAX_LANES=4).
// Two instances share stimulus: one MSB-first, one LSB-first.
module tb_width_down_serializer;

   logic        clk;
   logic        rst;
   logic        enb;
   logic [2:0]  dataS;
   logic [31:0] dataIn;
   logic        inValid;
   logic        outReady;

   logic        inReady_m, outValid_m, outLast_m, busy_m;
   logic [7:0]  dataOut_m;
   logic        inReady_l, outValid_l, outLast_l, busy_l;
   logic [7:0]  dataOut_l;

   int n_tests = 0;
   int n_fail  = 0;

   width_down_serializer #(.LANE_W(8), .MAX_LANES(4), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
      .inValid(inValid), .inReady(inReady_m), .dataOut(dataOut_m),
      .outValid(outValid_m), .outReady(outReady), .outLast(outLast_m),
      .busy(busy_m)
   );

   width_down_serializer #(.LANE_W(8), .MAX_LANES(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
      .inValid(inValid), .inReady(inReady_l), .dataOut(dataOut_l),
      .outValid(outValid_l), .outReady(outReady), .outLast(outLast_l),
      .busy(busy_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected lane sequences are left-justified: first emitted lane in [31:24].
   typedef struct {
      logic [2:0]  ds;
      logic [31:0] din;
      int          n;
      logic [31:0] msb_seq;
      logic [31:0] lsb_seq;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one table word with outReady=1 and check every emitted lane.
   // Entered and left at 1 time unit after a rising edge.
   task automatic apply_vec(input int i);
      logic [31:0] ms;
      logic [31:0] ls;
      ms = vecs[i].msb_seq;
      ls = vecs[i].lsb_seq;
      inValid  = 1'b1;
      dataS    = vecs[i].ds;
      dataIn   = vecs[i].din;
      outReady = 1'b1;
      @(negedge clk);
      chk("vec_inReady_idle", 64'(inReady_m), 64'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      dataIn  = 32'hFFFF_FFFF;   // later changes must not disturb the word
      dataS   = 3'd0;
      for (int l = 0; l < vecs[i].n; l++) begin
         @(negedge clk);
         chk("vec_msb_data",  64'(dataOut_m),  64'(ms[31-8*l -: 8]));
         chk("vec_lsb_data",  64'(dataOut_l),  64'(ls[31-8*l -: 8]));
         chk("vec_outValid",  64'(outValid_m), 64'd1);
         chk("vec_outLast",   64'(outLast_m),  64'(l == vecs[i].n-1));
         chk("vec_lsb_last",  64'(outLast_l),  64'(l == vecs[i].n-1));
         chk("vec_inReady",   64'(inReady_m),  64'(l == vecs[i].n-1));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("vec_done_valid", 64'(outValid_m), 64'd0);
      chk("vec_done_busy",  64'(busy_m),     64'd0);
      chk("vec_hold_data",  64'(dataOut_m),  64'(ms[31-8*(vecs[i].n-1) -: 8]));
      $display("[TB] word %h dataS=%0d lanes=%0d checked", vecs[i].din, vecs[i].ds, vecs[i].n);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] seq;

      vecs[0] = '{3'd2, 32'h95FD_AD43, 4, 32'h95FD_AD43, 32'h43AD_FD95};
      vecs[1] = '{3'd1, 32'h1234_AD43, 2, 32'hAD43_0000, 32'h43AD_0000};
      vecs[2] = '{3'd0, 32'hABCD_EF9A, 1, 32'h9A00_0000, 32'h9A00_0000};
      vecs[3] = '{3'd3, 32'h1122_3344, 4, 32'h1122_3344, 32'h4433_2211};
      vecs[4] = '{3'd7, 32'hA1B2_C3D4, 4, 32'hA1B2_C3D4, 32'hD4C3_B2A1};

      rst = 1'b1; enb = 1'b1; dataS = 3'd0; dataIn = '0;
      inValid = 1'b0; outReady = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_dataOut",  64'(dataOut_m),  64'd0);
      chk("rst_outValid", 64'(outValid_m), 64'd0);
      chk("rst_outLast",  64'(outLast_m),  64'd0);
      chk("rst_busy",     64'(busy_m),     64'd0);
      chk("rst_inReady",  64'(inReady_m),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven words
      for (int i = 0; i < 5; i++) apply_vec(i);

      // Back-to-back words with inValid held: no bubble
      seq = 64'h94D5_543F_0378_FDAE;
      inValid = 1'b1; dataS = 3'd2; dataIn = 32'h94D5_543F;
      @(negedge clk);
      chk("b2b_inReady0", 64'(inReady_m), 64'd1);
      @(posedge clk); #1;
      dataIn = 32'h0378_FDAE;
      for (int l = 0; l < 8; l++) begin
         @(negedge clk);
         chk("b2b_data",     64'(dataOut_m),  64'(seq[63-8*l -: 8]));
         chk("b2b_outValid", 64'(outValid_m), 64'd1);
         chk("b2b_outLast",  64'(outLast_m),  64'((l % 4) == 3));
         chk("b2b_inReady",  64'(inReady_m),  64'((l % 4) == 3));
         @(posedge clk); #1;
         if (l == 3) inValid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_busy_end", 64'(busy_m), 64'd0);
      $display("[TB] back-to-back words 94D5543F/0378FDAE checked");
      @(posedge clk); #1;

      // Backpressure: hold AD for 3 cycles
      inValid = 1'b1; dataS = 3'd2; dataIn = 32'h95FD_AD43;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(negedge clk);
      chk("bp_95", 64'(dataOut_m), 64'h95);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_FD", 64'(dataOut_m), 64'hFD);
      @(posedge clk); #1;
      outReady = 1'b0;
      inValid  = 1'b1; dataIn = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_hold_AD",   64'(dataOut_m),  64'hAD);
         chk("bp_outValid",  64'(outValid_m), 64'd1);
         chk("bp_outLast",   64'(outLast_m),  64'd0);
         chk("bp_inReady",   64'(inReady_m),  64'd0);
         @(posedge clk); #1;
      end
      outReady = 1'b1; inValid = 1'b0;
      @(negedge clk);
      chk("bp_AD_go", 64'(dataOut_m), 64'hAD);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_43",      64'(dataOut_m), 64'h43);
      chk("bp_43_last", 64'(outLast_m), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle", 64'(busy_m), 64'd0);
      $display("[TB] backpressure sequence checked");
      @(posedge clk); #1;

      // Enable low for 5 cycles after FD
      inValid = 1'b1; dataS = 3'd2; dataIn = 32'h95FD_AD43;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(negedge clk);
      chk("en_95", 64'(dataOut_m), 64'h95);
      @(posedge clk); #1;
      @(negedge clk);
      chk("en_FD", 64'(dataOut_m), 64'hFD);
      @(posedge clk); #1;
      enb = 1'b0; inValid = 1'b1; dataIn = 32'hDEAD_BEEF; dataS = 3'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("en_off_valid",   64'(outValid_m), 64'd0);
         chk("en_off_inReady", 64'(inReady_m),  64'd0);
         chk("en_off_data",    64'(dataOut_m),  64'hAD);
         chk("en_off_busy",    64'(busy_m),     64'd1);
         @(posedge clk); #1;
      end
      inValid = 1'b0; enb = 1'b1;
      @(negedge clk);
      chk("en_resume_AD", 64'(dataOut_m),  64'hAD);
      chk("en_resume_v",  64'(outValid_m), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("en_resume_43", 64'(dataOut_m), 64'h43);
      chk("en_resume_lst", 64'(outLast_m), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("en_idle", 64'(outValid_m), 64'd0);
      $display("[TB] enable-freeze sequence checked");
      @(posedge clk); #1;

      // Reset pulse mid-word
      inValid = 1'b1; dataS = 3'd2; dataIn = 32'h95FD_AD43;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(negedge clk);
      chk("rp_95", 64'(dataOut_m), 64'h95);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rp_dataOut",  64'(dataOut_m),  64'd0);
      chk("rp_outValid", 64'(outValid_m), 64'd0);
      chk("rp_busy",     64'(busy_m),     64'd0);
      chk("rp_inReady",  64'(inReady_m),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] mid-word reset checked");
      apply_vec(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
